uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12_000_000, meaning the SER_CLK frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 9600, meaning the line bit rate; CLKS_PER_BIT = CLK_HZ/UART_BAUD (integer divide, minimum 4).
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (legal values 1 or 2).
REQ-005 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity; used only with UART_RX_PARITY_EN.
REQ-006 SER_CLK  input  1  sole clock; all logic on its rising edge.
REQ-007 RST_N  input  1  asynchronous, active-low reset.
REQ-008 RX_SERIAL  input  1  asynchronous serial line; idles high.
REQ-009 RX_READY  input  1  consumer accepts RX_BYTE on a cycle where RX_DV=1 and RX_READY=1.
REQ-010 RX_DV  output  1  RX_BYTE holds an unconsumed valid byte.
REQ-011 RX_BYTE  output  DATA_BITS  received data, LSB first on the line, right-aligned.
REQ-012 FRAME_ERR  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-013 PARITY_ERR  output  1  one-cycle pulse when parity fails; tied 0 without UART_RX_PARITY_EN.
REQ-014 OVERRUN  output  1  one-cycle pulse when a good frame is dropped because the holding register is full.

Function
REQ-015 RX_SERIAL SHALL pass through a 2-flop synchroniser (reset value 1); all decisions use the synchronised bit.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; the counter SHALL be at least clog2(CLKS_PER_BIT)+1 bits and SHALL not wrap mid-bit.
REQ-017 IDLE->START on a synchronised low; START SHALL sample at count (CLKS_PER_BIT-1)/2 and go to DATA if low, else back to IDLE (glitch reject).
REQ-018 DATA, PARITY and STOP SHALL each sample once per CLKS_PER_BIT cycles, at bit centre; DATA SHALL capture DATA_BITS samples LSB first.
REQ-019 After DATA, the FSM SHALL enter PARITY when UART_RX_PARITY_EN is defined, else STOP.
REQ-020 STOP SHALL sample STOP_BITS stop bits; it SHALL return to IDLE right after the last stop-bit centre sample if all stop bits are high.
REQ-021 If any stop bit is low, the block SHALL pulse FRAME_ERR, discard the frame and enter WAIT_HIGH; WAIT_HIGH->IDLE on the first synchronised high (break tolerance).
REQ-022 A good frame SHALL load RX_BYTE and set RX_DV on the edge after the last stop-bit sample; RX_DV SHALL stay high until the RX_DV&RX_READY cycle, then clear on the next edge.
REQ-023 If a good frame completes while RX_DV=1 and RX_READY=0, RX_BYTE SHALL keep the old value and OVERRUN SHALL pulse.
REQ-024 If a good frame completes in the same cycle as RX_DV&RX_READY, the new byte SHALL load, RX_DV SHALL stay 1 and OVERRUN SHALL stay 0.
REQ-025 A frame with FRAME_ERR or PARITY_ERR SHALL never alter RX_BYTE or RX_DV.
REQ-026 Error and overrun flags SHALL be single-cycle pulses, never sticky.

Reset
REQ-027 RST_N low SHALL immediately force state IDLE, counters 0, synchroniser 1, RX_DV 0, RX_BYTE 0, FRAME_ERR 0, PARITY_ERR 0, OVERRUN 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the first falling edge after reset release SHALL be treated as a new start bit.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: the PARITY state samples one parity bit after the data bits; a mismatch with PARITY_ODD SHALL pulse PARITY_ERR, discard the byte and continue to the STOP check.
REQ-030 Macro UART_RX_PARITY_EN undefined: there SHALL be no PARITY state, no parity bit is expected, and PARITY_ERR SHALL be constant 0.

Verification (CLK_HZ=16, UART_BAUD=1, so 16 clocks per bit)
REQ-031 8N1 0xA5, RX_READY=1 -> RX_DV high exactly 1 cycle, RX_BYTE=0xA5, no error pulses.
REQ-032 RX_READY=0, frames 0x3C then 0x81 -> RX_BYTE stays 0x3C, one OVERRUN pulse; RX_READY=1 then clears RX_DV next edge.
REQ-033 Frame 0x55 with stop bit low, line low 3 bit-times, then high, then 0x12 -> one FRAME_ERR pulse, no RX_DV for 0x55, then RX_BYTE=0x12.
REQ-034 4-clock low glitch on idle line -> no RX_DV, no error pulses, FSM back in IDLE.
REQ-035 UART_RX_PARITY_EN defined, PARITY_ODD=0: 0x07 with parity bit 0 -> one PARITY_ERR pulse, no RX_DV; 0x07 with parity bit 1 -> RX_BYTE=0x07.
REQ-036 RST_N pulsed low during data bit 3, then frame 0xF0 -> all outputs 0 during reset, next RX_BYTE=0xF0.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with a one-byte ready/valid holding register.
// Optional parity check is built when the macro UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int UART_BAUD  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 SER_CLK,
  input  logic                 RST_N,
  input  logic                 RX_SERIAL,
  input  logic                 RX_READY,
  output logic                 RX_DV,
  output logic [DATA_BITS-1:0] RX_BYTE,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN
);
  localparam int CPB_RAW = CLK_HZ / UART_BAUD;
  localparam int CPB     = CPB_RAW < 4 ? 4 : CPB_RAW;
  localparam int CW      = $clog2(CPB) + 1;
  localparam int HALF    = (CPB - 1) / 2;

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter value");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic par_err_q, par_err_d, bad_q, bad_d;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
  logic                 sync1_q, sync2_q, dv_q, dv_d, frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d, good, bit_end, rx;

  assign rx      = sync2_q;
  assign bit_end = cnt_q == CW'(CPB - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    good        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = 1'b0;
    bad_d       = bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx ? IDLE : START;
      end
      START: begin
        cnt_d   = cnt_q == CW'(HALF) ? '0 : cnt_q + CW'(1);
        idx_d   = '0;
        state_d = cnt_q != CW'(HALF) ? START : rx ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        bad_d   = 1'b0;
`endif
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q == 3'(DATA_BITS - 1) ? 3'd0 : idx_q + 3'd1;
          state_d = idx_q == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          par_err_d = (^{shift_q, rx}) != (PARITY_ODD != 0);
          bad_d     = par_err_d;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          frame_err_d = !rx;
          idx_d       = idx_q + 3'd1;
          state_d     = !rx ? WAIT_HIGH : idx_q == 3'(STOP_BITS - 1) ? IDLE : STOP;
`ifdef UART_RX_PARITY_EN
          good        = rx && idx_q == 3'(STOP_BITS - 1) && !bad_q;
`else
          good        = rx && idx_q == 3'(STOP_BITS - 1);
`endif
        end
      end
      WAIT_HIGH: state_d = rx ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
  end

  // A consume in the same cycle frees the holding register for the new byte.
  always_comb begin
    dv_d      = good | (dv_q & ~RX_READY);
    byte_d    = good && (!dv_q || RX_READY) ? shift_q : byte_q;
    overrun_d = good & dv_q & ~RX_READY;
  end

  always_ff @(posedge SER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      dv_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      bad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      sync1_q     <= RX_SERIAL;
      sync2_q     <= sync1_q;
      dv_q        <= dv_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      bad_q       <= bad_d;
`endif
    end
  end

  assign RX_DV     = dv_q;
  assign RX_BYTE   = byte_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = par_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed and randomized frames against a frame-level receiver model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int CPB  = 16;
  localparam int MASK = 65535;
  // Bit j (start = 0) centre is seen LAT + CPB*j edges after its start edge is driven.
  localparam int LAT  = 4 + (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       SER_CLK = 1'b0, RST_N = 1'b0, RX_SERIAL = 1'b1, RX_READY = 1'b0;
  logic       RX_DV, FRAME_ERR, PARITY_ERR, OVERRUN;
  logic [7:0] RX_BYTE;

  int vectors = 0, miscompares = 0;
  int cyc = 0, epoch = 0;
  int ev_kind [65536];
  int ev_epoch [65536];
  logic [7:0] ev_data [65536];
  logic m_dv, m_fe, m_pe, m_ov;
  logic [7:0] m_byte;
  int cnt_dv = 0, cnt_fe = 0, cnt_pe = 0, cnt_ov = 0;
  bit rand_ready = 0;

  uart_rx_cfg #(.CLK_HZ(16), .UART_BAUD(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .SER_CLK(SER_CLK), .RST_N(RST_N), .RX_SERIAL(RX_SERIAL), .RX_READY(RX_READY),
    .RX_DV(RX_DV), .RX_BYTE(RX_BYTE), .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR),
    .OVERRUN(OVERRUN));

  always #5 SER_CLK = ~SER_CLK;
  always @(posedge SER_CLK) cyc <= cyc + 1;

  function automatic int kind_at(input int c);
    return ev_epoch[c & MASK] == epoch ? ev_kind[c & MASK] : 0;
  endfunction

  // Frame results (1 good byte, 2 framing error, 3 parity error) land on their scheduled edge.
  always @(posedge SER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_dv <= 0; m_byte <= 0; m_fe <= 0; m_pe <= 0; m_ov <= 0;
      epoch <= epoch + 1;
    end else begin
      m_fe <= kind_at(cyc + 1) == 2;
      m_pe <= kind_at(cyc + 1) == 3;
      m_ov <= kind_at(cyc + 1) == 1 && m_dv && !RX_READY;
      if (kind_at(cyc + 1) == 1 && (!m_dv || RX_READY)) begin
        m_byte <= ev_data[(cyc + 1) & MASK];
        m_dv   <= 1;
      end else if (m_dv && RX_READY) m_dv <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge SER_CLK);
      #1;
      if (rand_ready) RX_READY = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sched(input int at, input int kind, input logic [7:0] d);
    ev_kind[at & MASK]  = kind;
    ev_data[at & MASK]  = d;
    ev_epoch[at & MASK] = epoch;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    int k;
    logic pb;
    k  = cyc;
    pb = (^d) ^ !par_ok;
    if (P == 1 && !par_ok) sched(k + LAT + CPB * 9, 3, d);
    if (!stop_ok) sched(k + LAT + CPB * (9 + P), 2, d);
    else if (P == 0 || par_ok) sched(k + LAT + CPB * (9 + P), 1, d);
    RX_SERIAL = 0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX_SERIAL = d[i];
      tick(CPB);
    end
    if (P == 1) begin
      RX_SERIAL = pb;
      tick(CPB);
    end
    RX_SERIAL = stop_ok;
    tick(CPB);
  endtask

  initial begin
    fork
      forever begin
        @(negedge SER_CLK);
        chk("rx_dv", RX_DV, m_dv);
        chk("rx_byte", RX_BYTE, m_byte);
        chk("frame_err", FRAME_ERR, m_fe);
        chk("parity_err", PARITY_ERR, m_pe);
        chk("overrun", OVERRUN, m_ov);
        cnt_dv += RX_DV; cnt_fe += FRAME_ERR; cnt_pe += PARITY_ERR; cnt_ov += OVERRUN;
      end
      begin
        int b_dv, b_err;
        logic [7:0] d;
        bit s_ok, p_ok;
        tick(4);
        RST_N = 1;
        tick(4);
        // Single good frame, consumer always ready.
        RX_READY = 1;
        b_dv = cnt_dv; b_err = cnt_fe + cnt_pe + cnt_ov;
        send_frame(8'hA5, 1, 1);
        tick(20);
        @(negedge SER_CLK);
        chk("a5_byte", RX_BYTE, 8'hA5);
        chk("a5_dv_cycles", cnt_dv - b_dv, 1);
        chk("a5_err_pulses", cnt_fe + cnt_pe + cnt_ov - b_err, 0);
        // Overrun: second frame dropped while the first is unconsumed.
        RX_READY = 0;
        b_err = cnt_ov;
        send_frame(8'h3C, 1, 1);
        send_frame(8'h81, 1, 1);
        tick(20);
        @(negedge SER_CLK);
        chk("ovr_byte", RX_BYTE, 8'h3C);
        chk("ovr_dv_held", RX_DV, 1);
        chk("ovr_pulses", cnt_ov - b_err, 1);
        tick(1);
        RX_READY = 1;
        tick(1);
        @(negedge SER_CLK);
        chk("ovr_dv_cleared", RX_DV, 0);
        // Framing error followed by a break, then a good frame.
        b_dv = cnt_dv; b_err = cnt_fe;
        send_frame(8'h55, 0, 1);
        tick(3 * CPB);
        RX_SERIAL = 1;
        tick(20);
        send_frame(8'h12, 1, 1);
        tick(20);
        @(negedge SER_CLK);
        chk("fe_pulses", cnt_fe - b_err, 1);
        chk("fe_dv_cycles", cnt_dv - b_dv, 1);
        chk("fe_next_byte", RX_BYTE, 8'h12);
        // Short low glitch on an idle line must be rejected.
        b_dv = cnt_dv; b_err = cnt_fe + cnt_pe + cnt_ov;
        RX_SERIAL = 0;
        tick(4);
        RX_SERIAL = 1;
        tick(40);
        @(negedge SER_CLK);
        chk("glitch_dv", cnt_dv - b_dv, 0);
        chk("glitch_errs", cnt_fe + cnt_pe + cnt_ov - b_err, 0);
        send_frame(8'h96, 1, 1);
        tick(20);
        @(negedge SER_CLK);
        chk("glitch_next_byte", RX_BYTE, 8'h96);
`ifdef UART_RX_PARITY_EN
        b_err = cnt_pe;
        send_frame(8'h07, 1, 0);
        tick(20);
        @(negedge SER_CLK);
        chk("par_bad_byte", RX_BYTE, 8'h96);
        chk("par_pulses", cnt_pe - b_err, 1);
        send_frame(8'h07, 1, 1);
        tick(20);
        @(negedge SER_CLK);
        chk("par_good_byte", RX_BYTE, 8'h07);
`endif
        // Reset in the middle of data bit 3 while a byte is held.
        RX_READY = 0;
        send_frame(8'h5A, 1, 1);
        tick(4);
        @(negedge SER_CLK);
        chk("pre_rst_dv", RX_DV, 1);
        RX_SERIAL = 0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
          RX_SERIAL = 1'(i & 1);
          tick(CPB);
        end
        RX_SERIAL = 1;
        tick(CPB / 2);
        RST_N = 0;
        @(negedge SER_CLK);
        chk("rst_dv", RX_DV, 0);
        chk("rst_byte", RX_BYTE, 8'h00);
        chk("rst_flags", {FRAME_ERR, PARITY_ERR, OVERRUN}, 3'b000);
        tick(4);
        RST_N = 1;
        tick(4);
        RX_READY = 1;
        send_frame(8'hF0, 1, 1);
        tick(20);
        @(negedge SER_CLK);
        chk("post_rst_byte", RX_BYTE, 8'hF0);
        // Random frames, errors, glitches and consumer back-pressure.
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
          d    = 8'($urandom);
          s_ok = $urandom_range(0, 7) != 0;
          p_ok = P == 0 || $urandom_range(0, 5) != 0;
          send_frame(d, s_ok, p_ok);
          if (!s_ok) begin
            tick($urandom_range(0, 40));
            RX_SERIAL = 1;
            tick(2);
          end
          tick($urandom_range(0, 30));
          if ($urandom_range(0, 4) == 0) begin
            RX_SERIAL = 0;
            tick($urandom_range(1, 5));
            RX_SERIAL = 1;
            tick(12);
          end
        end
        rand_ready = 0;
        RX_READY = 1;
        tick(30);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
